// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// One full-adder slice with a registered carry evaluates a + ~b + 1.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CntW-1:0]  cnt;
    logic             carry;

    logic             sum;
    logic             cout;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        sum      = a_sr[0] ^ b_sr[0] ^ carry;
        cout     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        res_next = {sum, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= ~b;
                        carry <= 1'b1;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= StShift;
                    end
                end
                StShift: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= cout;
                    cnt    <= cnt + CntW'(1);
                    if (cnt == LastBit) begin
                        // carry holds the carry into the MSB here; cout is the carry out.
                        diff     <= res_next;
                        borrow   <= ~cout;
                        overflow <= carry ^ cout;
                        done     <= 1'b1;
                        state    <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 directed scenarios plus a
// back-to-back exhaustive sweep on a WIDTH=4 instance, scoreboarded against a reference model.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       br;
        logic       ov;
    } exp8_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, busy8, done8, borrow8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       start4, busy4, done4, borrow4, ovf4;
    logic [3:0] a4, b4, diff4;

    exp8_t      q8[$];
    logic [5:0] q4[$];
    int         n_checks = 0;
    int         n_pass = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .overflow(ovf4)
    );

    function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y);
        exp8_t r;
        r.d  = x - y;
        r.br = (x < y);
        r.ov = (x[7] != y[7]) && (r.d[7] != x[7]);
        return r;
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] d;
        d = x - y;
        return {d, (x < y), ((x[3] != y[3]) && (d[3] != x[3]))};
    endfunction

    // Drives one request; the edge following the setup negedge is the accept edge.
    task automatic issue8(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        q8.push_back(model8(x, y));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    // Counts negedges until done is seen; returns a value above the bound on timeout.
    task automatic wait_done8(output int k);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (done8) break;
        end
        if (!done8) k = 99;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0; start4 = 1'b0;
        a8 = 8'hA5; b8 = 8'h5A; a4 = 4'h3; b4 = 4'h9;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy8, done8, diff8, borrow8, ovf8, busy4, done4, diff4, borrow4, ovf4} !== '0) begin
            $display("FAIL reset_outputs: got %b %b %h %b %b / %b %b %h %b %b want all zero",
                     busy8, done8, diff8, borrow8, ovf8, busy4, done4, diff4, borrow4, ovf4);
        end else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_pos = -1;
        exp8_t e;
        issue8(8'h05, 8'h03);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                done_pos = k;
                e = q8.pop_front();
                n_checks++;
                if ({diff8, borrow8, ovf8} !== e) begin
                    $display("FAIL basic_result: got diff=%h br=%b ov=%b want diff=%h br=%b ov=%b",
                             diff8, borrow8, ovf8, e.d, e.br, e.ov);
                end else n_pass++;
            end
        end
        n_checks++;
        if (done_pos !== 9) $display("FAIL basic_latency: done at negedge %0d want 9", done_pos);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL basic_done_pulses: got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (busy_cnt !== 9) $display("FAIL basic_busy_cycles: got %0d want 9", busy_cnt);
        else n_pass++;
    endtask

    task automatic test_results();
        logic [15:0] tbl [4] = '{16'h0305, 16'h0000, 16'h8001, 16'h7FFF};
        exp8_t prev = model8(8'h05, 8'h03);
        exp8_t e;
        int k;
        for (int i = 0; i < 4; i++) begin
            issue8(tbl[i][15:8], tbl[i][7:0]);
            @(negedge clk);
            n_checks++;
            if (diff8 !== prev.d || borrow8 !== prev.br || ovf8 !== prev.ov) begin
                $display("FAIL hold_during_shift[%0d]: got diff=%h br=%b ov=%b want %h %b %b",
                         i, diff8, borrow8, ovf8, prev.d, prev.br, prev.ov);
            end else n_pass++;
            wait_done8(k);
            n_checks++;
            if (k !== 8) $display("FAIL result_latency[%0d]: got %0d want 8", i, k);
            else n_pass++;
            if (q8.size() != 0) begin
                e = q8.pop_front();
                n_checks++;
                if ({diff8, borrow8, ovf8} !== e) begin
                    $display("FAIL result[%0d]: got diff=%h br=%b ov=%b want diff=%h br=%b ov=%b",
                             i, diff8, borrow8, ovf8, e.d, e.br, e.ov);
                end else n_pass++;
                prev = e;
            end
        end
    endtask

    task automatic test_ignored_start();
        int done_cnt = 0;
        int pos [2] = '{-1, -1};
        exp8_t e;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        q8.push_back(model8(8'h10, 8'h01));
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) begin
                a8 = 8'hAA; b8 = 8'h55;
                q8.push_back(model8(8'hAA, 8'h55));
            end
            if (done8) begin
                if (done_cnt < 2) pos[done_cnt] = k;
                done_cnt++;
                e = q8.pop_front();
                n_checks++;
                if ({diff8, borrow8, ovf8} !== e) begin
                    $display("FAIL ignored_start_result: got diff=%h br=%b ov=%b want %h %b %b",
                             diff8, borrow8, ovf8, e.d, e.br, e.ov);
                end else n_pass++;
            end
        end
        start8 = 1'b0;
        n_checks++;
        if (done_cnt !== 2 || pos[0] !== 9 || pos[1] !== 19) begin
            $display("FAIL ignored_start_timing: got %0d dones at %0d,%0d want 2 at 9,19",
                     done_cnt, pos[0], pos[1]);
        end else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        exp8_t e;
        exp8_t unused_e;
        int spurious = 0;
        int k;
        issue8(8'h12, 8'h34);
        unused_e = q8.pop_back();
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy8, done8, diff8, borrow8, ovf8} !== '0) begin
            $display("FAIL mid_reset_outputs: got busy=%b done=%b diff=%h br=%b ov=%b want zero",
                     busy8, done8, diff8, borrow8, ovf8);
        end else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) spurious++;
        end
        n_checks++;
        if (spurious !== 0) $display("FAIL mid_reset_no_done: got %0d dones want 0", spurious);
        else n_pass++;
        issue8(8'hFF, 8'h01);
        wait_done8(k);
        n_checks++;
        if (k !== 9) $display("FAIL post_reset_latency: got %0d want 9", k);
        else n_pass++;
        e = q8.pop_front();
        n_checks++;
        if ({diff8, borrow8, ovf8} !== e) begin
            $display("FAIL post_reset_result: got diff=%h br=%b ov=%b want %h %b %b",
                     diff8, borrow8, ovf8, e.d, e.br, e.ov);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        int bad = 0;
        logic [5:0] e;
        fork
            begin
                @(negedge clk);
                start4 = 1'b1;
                for (int i = 0; i < 256; i++) begin
                    logic [7:0] pr = i[7:0];
                    a4 = pr[7:4];
                    b4 = pr[3:0];
                    q4.push_back(model4(pr[7:4], pr[3:0]));
                    repeat (6) @(posedge clk);
                    #1;
                end
                start4 = 1'b0;
            end
            begin
                for (int k = 0; k < 256 * 6 + 30; k++) begin
                    @(negedge clk);
                    if (done4) begin
                        done_cnt++;
                        n_checks++;
                        if (q4.size() == 0) begin
                            $display("FAIL sweep_unexpected_done: extra done at negedge %0d", k);
                        end else begin
                            e = q4.pop_front();
                            if ({diff4, borrow4, ovf4} !== e) begin
                                bad++;
                                $display("FAIL sweep_result[%0d]: got %h %b %b want %h %b %b",
                                         done_cnt - 1, diff4, borrow4, ovf4, e[5:2], e[1], e[0]);
                            end else n_pass++;
                        end
                    end
                end
            end
        join
        n_checks++;
        if (done_cnt !== 256) $display("FAIL sweep_count: got %0d dones want 256", done_cnt);
        else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_results();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
